// File: rtl/leg4_runctl.sv
// leg4 run controller: manual step, tick-paced free run and a PC breakpoint.
// Issues a one-cycle cpu_en per advance and counts executed instructions.
module leg4_runctl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             tick_slow,
   input  logic             tick_mid,
   input  logic             tick_fast,
   input  logic             run_en,
   input  logic             step_key,
   input  logic             bp_en,
   input  logic [3:0]       bp_addr,
   input  logic [3:0]       pc,
   input  logic             clr_cnt,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             brk_hit,
   output logic [CNT_W-1:0] cycles,
   output logic             cyc_ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_BRK  = 2'd3
   } state_t;

   state_t st_q, st_n;
   logic   cpu_en_n;
   logic   brk_n;
   logic   armed_q, armed_n;
   logic   step_q;
   logic   step_edge;
   logic   tick;
   logic   run_ok;

   assign step_edge = step_key & ~step_q;
   assign run_ok    = run_en & (mode != 2'd0);
   assign state     = st_q;

   always_comb begin
      tick = 1'b0;
      unique case (mode)
         2'd0: tick = 1'b0;
         2'd1: tick = tick_slow;
         2'd2: tick = tick_mid;
         2'd3: tick = tick_fast;
      endcase
   end

   always_comb begin
      st_n     = st_q;
      cpu_en_n = 1'b0;
      brk_n    = brk_hit;
      armed_n  = armed_q;
      unique case (st_q)
         S_IDLE: begin
            if (step_edge) begin
               st_n     = S_STEP;
               cpu_en_n = 1'b1;
            end else if (run_ok) begin
               st_n    = S_RUN;
               armed_n = 1'b0;
            end
         end
         S_STEP: st_n = S_IDLE;
         S_RUN: begin
            if (!run_ok) begin
               st_n = S_IDLE;
            end else if (tick) begin
               // armed stops a run resumed at the breakpoint from halting at once
               if (bp_en && armed_q && (pc == bp_addr)) begin
                  st_n  = S_BRK;
                  brk_n = 1'b1;
               end else begin
                  cpu_en_n = 1'b1;
                  armed_n  = 1'b1;
               end
            end
         end
         S_BRK: begin
            if (step_edge) begin
               st_n     = S_STEP;
               cpu_en_n = 1'b1;
               brk_n    = 1'b0;
            end else if (!run_en) begin
               st_n  = S_IDLE;
               brk_n = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= S_IDLE;
         cpu_en  <= 1'b0;
         brk_hit <= 1'b0;
         armed_q <= 1'b0;
         step_q  <= 1'b1;
      end else begin
         st_q    <= st_n;
         cpu_en  <= cpu_en_n;
         brk_hit <= brk_n;
         armed_q <= armed_n;
         step_q  <= step_key;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         cycles  <= '0;
         cyc_ovf <= 1'b0;
      end else if (cpu_en) begin
         if (&cycles) cyc_ovf <= 1'b1;
         else cycles <= cycles + 1'b1;
      end
   end

endmodule
